autocorr_16x160: RTL and testbench



---
 rtl/lpc_pkg.sv | 18 +
 rtl/autocorr_16x160_if.sv | 16 +
 rtl/lpc_mac.sv | 38 +++
 rtl/autocorr_16x160.sv | 113 +++++++++++
 tb/tb_autocorr_16x160.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/lpc_pkg.sv
// Constants and state type shared by the LPC analysis blocks
// (autocorrelation, windowing, Levinson-Durbin).
package lpc_pkg;

  localparam int FRAME_N   = 160;
  localparam int LPC_ORDER = 10;
  localparam int SAMPLE_W  = 16;
  localparam int ACC_W     = 40;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD_A = 3'd1,
    RD_B = 3'd2,
    OUT  = 3'd3,
    DONE = 3'd4
  } autocorr_state_t;

endpackage

// File: rtl/autocorr_16x160_if.sv
// Result stream from the autocorrelator to the Levinson-Durbin stage:
// one R[k] per transfer, in lag order, valid/ready handshake.
interface autocorr_16x160_if #(
  parameter int ACC_W = lpc_pkg::ACC_W,
  parameter int LAG_W = 4
) ();

  logic                    r_valid;
  logic                    r_ready;
  logic        [LAG_W-1:0] r_lag;
  logic signed [ACC_W-1:0] r_data;

  modport master (output r_valid, output r_lag, output r_data, input r_ready);
  modport slave  (input r_valid, input r_lag, input r_data, output r_ready);

endinterface

// File: rtl/lpc_mac.sv
// Registered signed multiply-accumulate with synchronous clear and enable;
// the full-precision product is sign-extended into the accumulator.
module lpc_mac #(
  parameter int DATA_W = lpc_pkg::SAMPLE_W,
  parameter int ACC_W  = lpc_pkg::ACC_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clr_i,
  input  logic                     en_i,
  input  logic signed [DATA_W-1:0] a_i,
  input  logic signed [DATA_W-1:0] b_i,
  output logic signed [ACC_W-1:0]  acc_o
);
  import lpc_pkg::*;

  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    acc_d, acc_q;

  always_comb begin
    prod  = (2*DATA_W)'(a_i) * (2*DATA_W)'(b_i);
    acc_d = acc_q;
    if (clr_i)
      acc_d = '0;
    else if (en_i)
      acc_d = acc_q + ACC_W'(prod);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      acc_q <= '0;
    else
      acc_q <= acc_d;
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/autocorr_16x160.sv
// Frame autocorrelation R[0..ORDER] over a 160-sample buffer, two buffer
// reads per MAC term, results streamed out in lag order.
module autocorr_16x160 #(
  parameter int N      = lpc_pkg::FRAME_N,
  parameter int ORDER  = lpc_pkg::LPC_ORDER,
  parameter int DATA_W = lpc_pkg::SAMPLE_W,
  parameter int ADDR_W = 8,
  parameter int ACC_W  = lpc_pkg::ACC_W,
  parameter int LAG_W  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic        [ADDR_W-1:0] raddr,
  input  logic signed [DATA_W-1:0] rdata,
  autocorr_16x160_if.master        res
);
  import lpc_pkg::*;

  autocorr_state_t            state_d, state_q;
  logic        [ADDR_W-1:0]   n_d, n_q;
  logic        [LAG_W-1:0]    k_d, k_q;
  logic signed [DATA_W-1:0]   a_d, a_q;
  logic                       mac_clr, mac_en;
  logic signed [ACC_W-1:0]    acc;

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    k_d     = k_q;
    a_d     = a_q;
    mac_clr = 1'b0;
    mac_en  = 1'b0;
    raddr   = '0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RD_A;
          n_d     = '0;
          k_d     = '0;
          mac_clr = 1'b1;
        end
      end
      RD_A: begin
        raddr   = n_q;
        a_d     = rdata;
        state_d = RD_B;
      end
      RD_B: begin
        // n starts at k for every lag, so n-k never wraps
        raddr  = n_q - ADDR_W'(k_q);
        mac_en = 1'b1;
        if (n_q == ADDR_W'(N-1)) begin
          state_d = OUT;
        end else begin
          n_d     = n_q + 1'b1;
          state_d = RD_A;
        end
      end
      OUT: begin
        if (res.r_ready) begin
          if (k_q == LAG_W'(ORDER)) begin
            state_d = DONE;
          end else begin
            k_d     = k_q + 1'b1;
            n_d     = ADDR_W'(k_q) + 1'b1;
            mac_clr = 1'b1;
            state_d = RD_A;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      n_q     <= '0;
      k_q     <= '0;
      a_q     <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      k_q     <= k_d;
      a_q     <= a_d;
    end
  end

  lpc_mac #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk   (clk),
    .reset (reset),
    .clr_i (mac_clr),
    .en_i  (mac_en),
    .a_i   (a_q),
    .b_i   (rdata),
    .acc_o (acc)
  );

  // Outputs decode straight from state so reset clears them without a clock
  assign busy        = (state_q == RD_A) || (state_q == RD_B) || (state_q == OUT);
  assign done        = (state_q == DONE);
  assign res.r_valid = (state_q == OUT);
  assign res.r_lag   = k_q;
  assign res.r_data  = acc;

endmodule

// File: tb/tb_autocorr_16x160.sv
// Bench for autocorr_16x160: frame buffer model, directed and random frames,
// backpressure, ignored start and mid-frame reset.
module tb_autocorr_16x160;

  localparam int N     = 160;
  localparam int ORDER = 10;
  localparam int LAT   = 3422;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        busy;
  logic        done;
  logic [7:0]  raddr;
  logic signed [15:0] rdata;

  logic signed [15:0] mem [N];
  longint             exp_r [ORDER+1];
  int                 checks = 0;
  int                 errors = 0;
  int                 cyc = 0;

  autocorr_16x160_if #(.ACC_W(40), .LAG_W(4)) rif ();

  autocorr_16x160 dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .busy  (busy),
    .done  (done),
    .raddr (raddr),
    .rdata (rdata),
    .res   (rif)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign rdata = (raddr < 8'(N)) ? mem[raddr] : 16'sd0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: R[k] = sum_{n=k}^{N-1} x[n]*x[n-k], plain integer arithmetic
  task automatic model();
    for (int k = 0; k <= ORDER; k++) begin
      exp_r[k] = 0;
      for (int n = k; n < N; n++)
        exp_r[k] += longint'(mem[n]) * longint'(mem[n-k]);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_busy"},  64'(busy), 64'd0);
    chk({tag, "_done"},  64'(done), 64'd0);
    chk({tag, "_raddr"}, 64'(raddr), 64'd0);
    chk({tag, "_valid"}, 64'(rif.r_valid), 64'd0);
    chk({tag, "_lag"},   64'(rif.r_lag), 64'd0);
    chk({tag, "_data"},  64'(rif.r_data), 64'd0);
  endtask

  task automatic run_frame(input string tag, input int stall_lag, input int reset_lag,
                           input bit start_dup, input bit chk_lat);
    int s;
    int idx;
    int stall_left;
    int done_cyc;
    int budget;
    bit fin;
    model();
    idx        = 0;
    stall_left = 5;
    fin        = 1'b0;
    done_cyc   = 0;
    rif.r_ready = 1'b1;
    @(posedge clk); #1;
    chk({tag, "_busy_pre"}, 64'(busy), 64'd0);
    start = 1'b1;
    s = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, "_busy_first"}, 64'(busy), 64'd1);
    for (budget = 0; budget < 4000 && !fin; budget++) begin
      start = start_dup && (cyc == s + 100);
      if (done) begin
        done_cyc = cyc;
        fin = 1'b1;
        chk({tag, "_done_valid"}, 64'(rif.r_valid), 64'd0);
        chk({tag, "_done_busy"}, 64'(busy), 64'd0);
      end else begin
        chk({tag, "_raddr_rng"}, 64'(raddr < 8'(N)), 64'd1);
        if (rif.r_valid) begin
          chk({tag, "_lag"}, 64'(rif.r_lag), 64'(idx));
          chk({tag, "_data"}, 64'(rif.r_data), (idx <= ORDER) ? 64'(exp_r[idx]) : 64'd0);
          if (idx == reset_lag) begin
            reset = 1'b1;
            #1;
            check_idle_outputs({tag, "_rst"});
            reset = 1'b0;
            return;
          end else if (idx == stall_lag && stall_left > 0) begin
            rif.r_ready = 1'b0;
            chk({tag, "_stall_raddr"}, 64'(raddr), 64'd0);
            chk({tag, "_stall_busy"}, 64'(busy), 64'd1);
            stall_left--;
          end else begin
            rif.r_ready = 1'b1;
            idx++;
          end
        end else begin
          rif.r_ready = 1'b1;
        end
        @(posedge clk); #1;
      end
    end
    start = 1'b0;
    chk({tag, "_finished"}, 64'(fin), 64'd1);
    chk({tag, "_count"}, 64'(idx), 64'(ORDER+1));
    if (chk_lat)
      chk({tag, "_latency"}, 64'(done_cyc - s), 64'(LAT));
    if (stall_lag >= 0)
      chk({tag, "_stall_len"}, 64'(stall_left), 64'd0);
    @(posedge clk); #1;
    chk({tag, "_done_pulse"}, 64'(done), 64'd0);
    chk({tag, "_idle_busy"}, 64'(busy), 64'd0);
  endtask

  initial begin
    reset       = 1'b1;
    start       = 1'b0;
    rif.r_ready = 1'b1;
    for (int i = 0; i < N; i++) mem[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    reset = 1'b0;
    @(posedge clk); #1;
    check_idle_outputs("post_reset");

    run_frame("zeros", -1, -1, 1'b0, 1'b1);

    for (int i = 0; i < N; i++) mem[i] = 16'sh0001;
    run_frame("ones", -1, -1, 1'b0, 1'b1);

    for (int i = 0; i < N; i++) mem[i] = '0;
    mem[0] = 16'sh7FFF;
    run_frame("impulse", -1, -1, 1'b0, 1'b1);

    for (int i = 0; i < N; i++) mem[i] = (i % 2 == 0) ? 16'sh0001 : -16'sh0001;
    run_frame("alt", -1, -1, 1'b0, 1'b1);

    for (int i = 0; i < N; i++) mem[i] = 16'sh8000;
    run_frame("minval", -1, -1, 1'b0, 1'b1);
    run_frame("minval_stall", 3, -1, 1'b0, 1'b0);

    for (int i = 0; i < N; i++) mem[i] = 16'($urandom);
    run_frame("rand_dup", -1, -1, 1'b1, 1'b1);
    run_frame("rand_stall", 3, -1, 1'b0, 1'b0);

    for (int i = 0; i < N; i++) mem[i] = 16'($urandom);
    run_frame("rand_rst", -1, 5, 1'b0, 1'b0);
    run_frame("rand_after_rst", -1, -1, 1'b0, 1'b1);

    for (int i = 0; i < N; i++) mem[i] = 16'(int'($urandom_range(0, 200)) - 100);
    run_frame("rand_small", -1, -1, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
